// File: rtl/match_event_logger.sv
// match_event_logger: timestamps match pulses into a show-ahead FIFO with match count and sticky overflow; MATCH_CNT_SAT_EN makes match_count saturate
module match_event_logger #(
  parameter int TS_W = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       match,
  input  logic                       ev_ready,
  input  logic                       clr_ovf,
  output logic                       ev_valid,
  output logic [TS_W-1:0]            ev_time,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [CNT_W-1:0]           match_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, pop, push;
  logic [TS_W-1:0] mem_q [DEPTH];
  logic [TS_W-1:0] mem_d [DEPTH];
  always_comb begin
    pop = lvl_q != '0 && ev_ready;
    push = match && (lvl_q != LW'(DEPTH) || pop);
    ts_d = ts_q + TS_W'(1);
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    lvl_d = lvl_q + LW'(push) - LW'(pop);
`ifdef MATCH_CNT_SAT_EN
    cnt_d = (match && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
`else
    cnt_d = cnt_q + CNT_W'(match);
`endif
    ovf_d = (match && !push) || (ovf_q && !clr_ovf);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = ts_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ts_q <= ts_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign ev_valid = lvl_q != '0;
  assign ev_time = ev_valid ? mem_q[rp_q] : '0;
  assign fifo_level = lvl_q;
  assign match_count = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_match_event_logger.sv
// tb_match_event_logger: queue-model check of match_event_logger plus a narrow instance for counter/timestamp wrap
module tb_match_event_logger;
  logic clk = 1'b0;
  logic reset = 1'b1, match = 1'b0, ev_ready = 1'b0, clr_ovf = 1'b0;
  logic ev_valid, overflow;
  logic [15:0] ev_time;
  logic [2:0] fifo_level;
  logic [7:0] match_count;
  logic rst2 = 1'b1, m2 = 1'b0, r2 = 1'b0, c2 = 1'b0;
  logic ev_valid2, ovf2;
  logic [3:0] ev_time2;
  logic [1:0] lvl2;
  logic [2:0] mc2;
  int n = 0, errs = 0;
  int mts = 0, mcnt = 0;
  logic movf = 1'b0;
  logic [15:0] q[$];
`ifdef MATCH_CNT_SAT_EN
  localparam int SAT = 1;
  localparam int EXP9 = 7;
`else
  localparam int SAT = 0;
  localparam int EXP9 = 1;
`endif
  match_event_logger dut (
    .clk(clk), .reset(reset), .match(match), .ev_ready(ev_ready), .clr_ovf(clr_ovf),
    .ev_valid(ev_valid), .ev_time(ev_time), .fifo_level(fifo_level),
    .match_count(match_count), .overflow(overflow)
  );
  match_event_logger #(.TS_W(4), .CNT_W(3), .DEPTH(2)) dut2 (
    .clk(clk), .reset(rst2), .match(m2), .ev_ready(r2), .clr_ovf(c2),
    .ev_valid(ev_valid2), .ev_time(ev_time2), .fifo_level(lvl2),
    .match_count(mc2), .overflow(ovf2)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cmp();
    chk("valid", 32'(ev_valid), 32'(q.size() != 0));
    chk("time", 32'(ev_time), q.size() != 0 ? 32'(q[0]) : 32'd0);
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("count", 32'(match_count), 32'(mcnt));
    chk("ovf", 32'(overflow), 32'(movf));
  endtask
  task automatic step(logic m, logic r, logic c, logic rs);
    logic pop, drop;
    match = m; ev_ready = r; clr_ovf = c; reset = rs;
    @(posedge clk);
    if (rs) begin
      q.delete(); mcnt = 0; movf = 1'b0; mts = 0;
    end else begin
      pop = q.size() != 0 && r;
      drop = m && q.size() == 4 && !pop;
      if (pop) void'(q.pop_front());
      if (m && !drop) q.push_back(16'(mts));
      if (m) mcnt = SAT ? (mcnt == 255 ? 255 : mcnt + 1) : (mcnt + 1) % 256;
      movf = drop ? 1'b1 : c ? 1'b0 : movf;
      mts = (mts + 1) % 65536;
    end
    #1;
    cmp();
  endtask
  task automatic idle_to(int t);
    for (int k = 0; k < 100 && mts != t; k++) step(0, 0, 0, 0);
  endtask
  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_valid", 32'(ev_valid), 0);
    idle_to(5);
    step(1, 0, 0, 0);
    chk("single_time", 32'(ev_time), 5);
    chk("single_level", 32'(fifo_level), 1);
    chk("single_count", 32'(match_count), 1);
    chk("single_valid", 32'(ev_valid), 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      idle_to(10 + 4 * i);
      step(1, 0, 0, 0);
    end
    chk("fill_level", 32'(fifo_level), 4);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_count", 32'(match_count), 5);
    for (int i = 0; i < 4; i++) begin
      chk("drain", 32'(ev_time), 32'(10 + 4 * i));
      step(0, 1, 0, 0);
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      idle_to(10 + 4 * i);
      step(1, 0, 0, 0);
    end
    idle_to(30);
    step(1, 1, 0, 0);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_level", 32'(fifo_level), 4);
    for (int i = 0; i < 4; i++) begin
      chk("pp_drain", 32'(ev_time), 32'(14 + 4 * i + (i == 3 ? 4 : 0)));
      step(0, 1, 0, 0);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("clr_prio", 32'(overflow), 1);
    step(0, 0, 1, 0);
    chk("clr_only", 32'(overflow), 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("mid_level", 32'(fifo_level), 3);
    chk("mid_ovf", 32'(overflow), 1);
    step(1, 0, 0, 1);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_time", 32'(ev_time), 0);
    chk("mid_rst_count", 32'(match_count), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_valid", 32'(ev_valid), 0);
    rst2 = 1'b1;
    step(0, 0, 0, 0);
    rst2 = 1'b0;
    m2 = 1'b1;
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
    m2 = 1'b0;
    step(0, 0, 0, 0);
    chk("cnt_boundary", 32'(mc2), 32'(EXP9));
    rst2 = 1'b1;
    step(0, 0, 0, 0);
    rst2 = 1'b0;
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
    m2 = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    m2 = 1'b0;
    chk("ts_wrap_level", 32'(lvl2), 2);
    chk("ts_wrap_first", 32'(ev_time2), 15);
    r2 = 1'b1;
    step(0, 0, 0, 0);
    r2 = 1'b0;
    chk("ts_wrap_second", 32'(ev_time2), 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
